// File: rtl/mesa_ascii2byte.sv
// ASCII-hex to binary byte assembler for a UART receive path: pairs hex digits
// into bytes, flags LF as end of packet. Define MESA_ASCII2BYTE_LOWERCASE_EN to accept a-f.
module mesa_ascii2byte (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_char_d,
  input  logic       rx_char_en,
  output logic [7:0] rx_byte_d,
  output logic       rx_byte_en,
  input  logic       rx_byte_busy,
  output logic       rx_packet_done,
  output logic       rx_char_err,
  output logic       rx_overflow
);

  typedef enum logic {
    NIB_HI = 1'b0,
    NIB_LO = 1'b1
  } nib_state_e;

  nib_state_e state_q, state_d;
  logic [3:0] hi_nib_q, hi_nib_d;
  logic [7:0] pend_byte_q, pend_byte_d;
  logic       pending_q, pending_d;
  logic       done_pending_q, done_pending_d;
  logic [7:0] byte_q, byte_d;
  logic       byte_en_q, byte_en_d;
  logic       packet_done_q, packet_done_d;
  logic       char_err_q, char_err_d;
  logic       overflow_q, overflow_d;

  logic       is_hex;
  logic [3:0] hex_val;
  logic       is_lf;
  logic       is_skip;
  logic       byte_done;
  logic       lf_seen;
  logic [7:0] new_byte;
  logic       release_now;
  logic       done_fire;

  // Character classification
  always_comb begin
    is_hex  = 1'b0;
    hex_val = 4'h0;
    if (rx_char_d >= 8'h30 && rx_char_d <= 8'h39) begin
      is_hex  = 1'b1;
      hex_val = rx_char_d[3:0];
    end else if (rx_char_d >= 8'h41 && rx_char_d <= 8'h46) begin
      is_hex  = 1'b1;
      hex_val = rx_char_d[3:0] + 4'd9;
    end
`ifdef MESA_ASCII2BYTE_LOWERCASE_EN
    else if (rx_char_d >= 8'h61 && rx_char_d <= 8'h66) begin
      is_hex  = 1'b1;
      hex_val = rx_char_d[3:0] + 4'd9;
    end
`endif
    is_lf   = (rx_char_d == 8'h0A);
    is_skip = (rx_char_d == 8'h0D) || (rx_char_d == 8'h20);
  end

  // Nibble FSM
  always_comb begin
    state_d    = state_q;
    hi_nib_d   = hi_nib_q;
    char_err_d = 1'b0;
    byte_done  = 1'b0;
    lf_seen    = 1'b0;
    if (rx_char_en) begin
      if (is_hex) begin
        if (state_q == NIB_HI) begin
          hi_nib_d = hex_val;
          state_d  = NIB_LO;
        end else begin
          byte_done = 1'b1;
          state_d   = NIB_HI;
        end
      end else if (is_lf) begin
        lf_seen = 1'b1;
        if (state_q == NIB_LO) char_err_d = 1'b1;
        state_d = NIB_HI;
      end else if (!is_skip) begin
        char_err_d = 1'b1;
        state_d    = NIB_HI;
      end
    end
  end

  assign new_byte    = {hi_nib_q, hex_val};
  assign release_now = pending_q && !rx_byte_busy;

  // Byte hand-off: a held byte goes out first; when it leaves on the same edge
  // a new byte completes, the new byte waits in pend_byte while rx_byte_d still
  // shows the outgoing one for its strobe cycle.
  always_comb begin
    pend_byte_d = pend_byte_q;
    pending_d   = pending_q;
    byte_en_d   = 1'b0;
    byte_d      = pending_q ? pend_byte_q : byte_q;
    overflow_d  = overflow_q;
    if (release_now) begin
      byte_en_d = 1'b1;
      byte_d    = pend_byte_q;
      pending_d = 1'b0;
    end
    if (byte_done) begin
      if (pending_q && !release_now) begin
        overflow_d = 1'b1;
      end else if (release_now || rx_byte_busy) begin
        pend_byte_d = new_byte;
        pending_d   = 1'b1;
        if (!release_now) byte_d = new_byte;
      end else begin
        byte_en_d = 1'b1;
        byte_d    = new_byte;
      end
    end
  end

  // End-of-packet waits until no byte is left undelivered
  always_comb begin
    done_fire      = done_pending_q && !pending_q;
    packet_done_d  = done_fire;
    done_pending_d = (done_pending_q && !done_fire) || lf_seen;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= NIB_HI;
      hi_nib_q       <= 4'h0;
      pend_byte_q    <= 8'h00;
      pending_q      <= 1'b0;
      done_pending_q <= 1'b0;
      byte_q         <= 8'h00;
      byte_en_q      <= 1'b0;
      packet_done_q  <= 1'b0;
      char_err_q     <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      hi_nib_q       <= hi_nib_d;
      pend_byte_q    <= pend_byte_d;
      pending_q      <= pending_d;
      done_pending_q <= done_pending_d;
      byte_q         <= byte_d;
      byte_en_q      <= byte_en_d;
      packet_done_q  <= packet_done_d;
      char_err_q     <= char_err_d;
      overflow_q     <= overflow_d;
    end
  end

  assign rx_byte_d      = byte_q;
  assign rx_byte_en     = byte_en_q;
  assign rx_packet_done = packet_done_q;
  assign rx_char_err    = char_err_q;
  assign rx_overflow    = overflow_q;

endmodule

// File: tb/tb_mesa_ascii2byte.sv
// Bench for mesa_ascii2byte: directed scenarios plus a random character stream
// checked against a string-parsing reference model.
module tb_mesa_ascii2byte;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_char_d;
  logic       rx_char_en;
  logic [7:0] rx_byte_d;
  logic       rx_byte_en;
  logic       rx_byte_busy;
  logic       rx_packet_done;
  logic       rx_char_err;
  logic       rx_overflow;

  mesa_ascii2byte dut (
    .clk            (clk),
    .reset          (reset),
    .rx_char_d      (rx_char_d),
    .rx_char_en     (rx_char_en),
    .rx_byte_d      (rx_byte_d),
    .rx_byte_en     (rx_byte_en),
    .rx_byte_busy   (rx_byte_busy),
    .rx_packet_done (rx_packet_done),
    .rx_char_err    (rx_char_err),
    .rx_overflow    (rx_overflow)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Scoreboard storage
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  int         done_t[$];
  int         err_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_byte_en) begin
        got_q.push_back(rx_byte_d);
        got_t.push_back(cyc);
      end
      if (rx_packet_done) done_t.push_back(cyc);
      if (rx_char_err) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return {24'h0, got_q[i]};
    return 32'hxxxx_xxxx;
  endfunction

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, output int t);
    rx_char_d  = c;
    rx_char_en = 1'b1;
    @(posedge clk);
    #1;
    t          = cyc;
    rx_char_en = 1'b0;
    rx_char_d  = 8'h00;
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_t.delete();
    done_t.delete();
    err_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    clear_mon();
  endtask

  // Reference decode straight from the character table
  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
`ifdef MESA_ASCII2BYTE_LOWERCASE_EN
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
`endif
    return -1;
  endfunction

  logic [7:0] pool[20] = '{8'h30, 8'h35, 8'h39, 8'h41, 8'h43, 8'h46, 8'h61, 8'h66,
                           8'h47, 8'h67, 8'h2F, 8'h3A, 8'h40, 8'h0A, 8'h0D, 8'h20,
                           8'h33, 8'h37, 8'h42, 8'h45};

  initial begin
    int t, tf, tl;
    int held, hi, v, exp_err, exp_done;
    logic [7:0] c;

    reset        = 1'b1;
    rx_char_en   = 1'b0;
    rx_char_d    = 8'h00;
    rx_byte_busy = 1'b0;
    idle(3);
    check("rst_byte_en", rx_byte_en, 0);
    check("rst_byte_d", rx_byte_d, 8'h00);
    check("rst_done", rx_packet_done, 0);
    check("rst_err", rx_char_err, 0);
    check("rst_ovf", rx_overflow, 0);
    reset = 1'b0;
    clear_mon();

    // "3","F": one byte, visible the cycle right after the F strobe
    send("3", t);
    send("F", tf);
    idle(4);
    check("t1_count", got_q.size(), 1);
    check("t1_byte", got_at(0), 8'h3F);
    check("t1_latency", got_t.size() > 0 ? got_t[0] : -1, tf);
    check("t1_err", err_cnt, 0);
    clear_mon();

    // "A","5",LF: byte then one packet_done
    send("A", t);
    send("5", t);
    send(8'h0A, tl);
    idle(4);
    check("t2_count", got_q.size(), 1);
    check("t2_byte", got_at(0), 8'hA5);
    check("t2_done_cnt", done_t.size(), 1);
    check("t2_done_time", done_t.size() > 0 ? done_t[0] : -1, tl + 1);
    check("t2_err", err_cnt, 0);
    clear_mon();

    // Busy hold and overflow
    rx_byte_busy = 1'b1;
    send("1", t);
    send("2", t);
    idle(10);
    check("t3_hold_d", rx_byte_d, 8'h12);
    check("t3_hold_en", rx_byte_en, 0);
    send("3", t);
    send("4", t);
    idle(2);
    check("t3_ovf", rx_overflow, 1);
    check("t3_none_yet", got_q.size(), 0);
    check("t3_still_d", rx_byte_d, 8'h12);
    rx_byte_busy = 1'b0;
    idle(4);
    check("t3_count", got_q.size(), 1);
    check("t3_byte", got_at(0), 8'h12);
    check("t3_ovf_sticky", rx_overflow, 1);
    do_reset();
    check("t3_ovf_clr", rx_overflow, 0);

    // Illegal char mid-byte
    send("7", t);
    send("G", t);
    send("8", t);
    send("9", t);
    idle(4);
    check("t4_err", err_cnt, 1);
    check("t4_count", got_q.size(), 1);
    check("t4_byte", got_at(0), 8'h89);
    clear_mon();

    // Lowercase digits
    send("b", t);
    send("c", t);
    idle(4);
`ifdef MESA_ASCII2BYTE_LOWERCASE_EN
    check("t5_count", got_q.size(), 1);
    check("t5_byte", got_at(0), 8'hBC);
    check("t5_err", err_cnt, 0);
`else
    check("t5_count", got_q.size(), 0);
    check("t5_err", err_cnt, 2);
`endif
    clear_mon();

    // Reset discards a held nibble
    send("4", t);
    do_reset();
    send("5", t);
    send("6", t);
    idle(4);
    check("t6_count", got_q.size(), 1);
    check("t6_byte", got_at(0), 8'h56);
    check("t6_ovf", rx_overflow, 0);
    clear_mon();

    // Reset beats a simultaneous char and drops a pending byte
    rx_byte_busy = 1'b1;
    send("1", t);
    send("2", t);
    rx_char_d  = "3";
    rx_char_en = 1'b1;
    reset      = 1'b1;
    idle(1);
    rx_char_en   = 1'b0;
    idle(1);
    reset        = 1'b0;
    rx_byte_busy = 1'b0;
    clear_mon();
    idle(4);
    check("t7_no_byte", got_q.size(), 0);
    send("9", t);
    send("9", t);
    idle(3);
    check("t7_fresh", got_at(0), 8'h99);
    clear_mon();

    // LF with a held nibble; CR and space ignored
    send("7", t);
    send(8'h0A, t);
    send("1", t);
    send(8'h20, t);
    send(8'h0D, t);
    send("2", t);
    idle(4);
    check("t8_err", err_cnt, 1);
    check("t8_done", done_t.size(), 1);
    check("t8_count", got_q.size(), 1);
    check("t8_byte", got_at(0), 8'h12);
    clear_mon();

    // packet_done waits for a held byte
    rx_byte_busy = 1'b1;
    send("9", t);
    send("C", t);
    send(8'h0A, t);
    idle(5);
    check("t9_done_wait", done_t.size(), 0);
    rx_byte_busy = 1'b0;
    idle(4);
    check("t9_byte", got_at(0), 8'h9C);
    check("t9_done_cnt", done_t.size(), 1);
    check("t9_done_after", (done_t.size() > 0 && got_t.size() > 0) ? done_t[0] - got_t[0] : -1, 1);
    do_reset();

    // Random stream against the parsing model
    exp_q.delete();
    held     = 0;
    hi       = 0;
    exp_err  = 0;
    exp_done = 0;
    for (int i = 0; i < 400; i++) begin
      c = pool[$urandom_range(0, 19)];
      v = hexval(c);
      if (c == 8'h0D || c == 8'h20) begin
      end else if (c == 8'h0A) begin
        if (held != 0) exp_err++;
        held = 0;
        exp_done++;
      end else if (v >= 0) begin
        if (held != 0) begin
          exp_q.push_back(8'(hi * 16 + v));
          held = 0;
        end else begin
          hi   = v;
          held = 1;
        end
      end else begin
        exp_err++;
        held = 0;
      end
      send(c, t);
      idle($urandom_range(0, 2));
    end
    idle(5);
    check("rand_count", got_q.size(), exp_q.size());
    check("rand_err", err_cnt, exp_err);
    check("rand_done", done_t.size(), exp_done);
    for (int i = 0; i < exp_q.size(); i++) check("rand_byte", got_at(i), {24'h0, exp_q[i]});
    check("rand_ovf", rx_overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesa_ascii2byte.md
MESA_ASCII2BYTE -- requirements
Module: mesa_ascii2byte

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all logic.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: rx_char_d  input  8  ASCII character from UART receiver.
REQ-004 SHALL have port: rx_char_en  input  1  one-cycle strobe qualifying rx_char_d.
REQ-005 SHALL have port: rx_byte_d  output  8  assembled binary byte, valid when rx_byte_en=1.
REQ-006 SHALL have port: rx_byte_en  output  1  one-cycle strobe for rx_byte_d.
REQ-007 SHALL have port: rx_byte_busy  input  1  downstream not ready; holds the pending byte.
REQ-008 SHALL have port: rx_packet_done  output  1  one-cycle pulse marking end of line ("\n").
REQ-009 SHALL have port: rx_char_err  output  1  one-cycle pulse on an illegal character or an orphan nibble.
REQ-010 SHALL have port: rx_overflow  output  1  sticky flag; a completed byte was dropped.

Function
REQ-011 SHALL decode hex digits: 0x30-0x39 -> 0x0-0x9; 0x41-0x46 -> 0xA-0xF.
REQ-012 SHALL implement a two-state nibble FSM: NIB_HI (no nibble held), NIB_LO (high nibble held).
REQ-013 SHALL, on a valid digit in NIB_HI, store it as the high nibble and go to NIB_LO.
REQ-014 SHALL, on a valid digit in NIB_LO, form {hi,lo} into a pending byte register, set pending, and go to NIB_HI.
REQ-015 SHALL assert rx_byte_en, with rx_byte_d equal to the pending byte, for exactly one cycle on the first cycle where pending=1 and rx_byte_busy=0, then clear pending.
REQ-016 SHALL give a latency of 1 cycle: the strobe on the low-nibble rx_char_en at cycle N produces rx_byte_en at cycle N+1 when rx_byte_busy=0 at N+1.
REQ-017 SHALL hold rx_byte_d stable while pending=1 and rx_byte_busy=1.
REQ-018 SHALL, when a byte completes while pending=1 and it is not released that cycle, drop the new byte, keep the old one, and set rx_overflow until reset.
REQ-019 SHALL ignore 0x0D (CR) and 0x20 (space): no state change and no error.
REQ-020 SHALL, on 0x0A (LF) in NIB_HI, set done_pending.
REQ-021 SHALL, on 0x0A (LF) in NIB_LO, discard the held nibble, pulse rx_char_err, set done_pending, and go to NIB_HI.
REQ-022 SHALL pulse rx_packet_done one cycle after done_pending is set if pending=0; otherwise it SHALL pulse on the cycle after the held byte's rx_byte_en.
REQ-023 SHALL, on any other character, pulse rx_char_err on the next cycle, discard any held nibble, and go to NIB_HI; a pending byte is unaffected.
REQ-024 SHALL ignore rx_char_d whenever rx_char_en=0.
REQ-025 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, while reset=1, force FSM=NIB_HI, pending=0, done_pending=0, and rx_byte_en=0, rx_packet_done=0, rx_char_err=0, rx_overflow=0, rx_byte_d=0x00.
REQ-027 SHALL give reset priority over a simultaneous rx_char_en; a mid-byte nibble or pending byte is discarded with no strobe.

Configuration
REQ-028 SHALL, when macro MESA_ASCII2BYTE_LOWERCASE_EN is defined, also decode 0x61-0x66 -> 0xA-0xF.
REQ-029 SHALL, when MESA_ASCII2BYTE_LOWERCASE_EN is undefined, treat 0x61-0x66 as illegal per REQ-023.

Verification
REQ-030 SHALL verify: chars "3","F" with busy=0 -> one rx_byte_en with rx_byte_d=0x3F, one cycle after the "F" strobe.
REQ-031 SHALL verify: "A","5","\n" -> rx_byte_d=0xA5 strobe, then a single rx_packet_done pulse, and no rx_char_err.
REQ-032 SHALL verify: "1","2" with busy=1 for 10 cycles, then "3","4" -> 0x12 held, 0x34 dropped, rx_overflow=1, and 0x12 is emitted when busy drops.
REQ-033 SHALL verify: "7","G","8","9" -> rx_char_err pulse, then rx_byte_d=0x89, and no byte containing 0x7.
REQ-034 SHALL verify: "b","c" -> 0xBC with the macro defined; two rx_char_err pulses and no byte without it.
REQ-035 SHALL verify: "4", then reset, then "5","6" -> single rx_byte_d=0x56 and rx_overflow=0.
